// File: rtl/rv_defs.sv
// rv_defs: shared RV32I decode constants and operand-usage helpers for the issue stage
package rv_defs;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int OPC_W = 7;
    localparam int REG_W = 5;
    localparam int RD_LO = 7;
    localparam int RS1_LO = 15;
    localparam int RS2_LO = 20;
    localparam logic [OPC_W-1:0] OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;

    function automatic logic uses_rs1(input logic [OPC_W-1:0] op);
        return !(op inside {LUI, AUIPC, JAL});
    endfunction

    function automatic logic uses_rs2(input logic [OPC_W-1:0] op);
        return op inside {OP, STORE, BRANCH};
    endfunction

    // rd != 0 is qualified by the caller
    function automatic logic writes_rd(input logic [OPC_W-1:0] op);
        return op inside {OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD};
    endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: integer register file, two async read ports with write-through bypass, x0 reads zero
module reg_file #(
    parameter int XLEN = rv_defs::XLEN,
    parameter int NREG = rv_defs::NREG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [XLEN-1:0]         wdata,
    input  logic [$clog2(NREG)-1:0] raddr1,
    output logic [XLEN-1:0]         rdata1,
    input  logic [$clog2(NREG)-1:0] raddr2,
    output logic [XLEN-1:0]         rdata2
);
    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        else if (we && waddr != '0)
            regs[waddr] <= wdata;
    end

    assign rdata1 = raddr1 == '0 ? '0 : (we && waddr == raddr1) ? wdata : regs[raddr1];
    assign rdata2 = raddr2 == '0 ? '0 : (we && waddr == raddr2) ? wdata : regs[raddr2];
endmodule

// File: rtl/reg_issue.sv
// reg_issue: operand-issue stage with pending scoreboard, hazard stall and writeback forwarding
module reg_issue
    import rv_defs::*;
#(
    parameter int XLEN = rv_defs::XLEN,
    parameter int NREG = rv_defs::NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    input  logic            wb_valid,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data
);
    logic [REG_W-1:0] rs1a, rs2a, rda;
    logic [OPC_W-1:0] opc;
    logic             u1, u2, wr, hazard, issue;
    logic [NREG-1:0]  pending, wb_clr, busy, pend_set;
    logic [XLEN-1:0]  rd1, rd2;

    assign opc  = in_inst[OPC_W-1:0];
    assign rda  = in_inst[RD_LO +: REG_W];
    assign rs1a = in_inst[RS1_LO +: REG_W];
    assign rs2a = in_inst[RS2_LO +: REG_W];
    assign u1   = uses_rs1(opc);
    assign u2   = uses_rs2(opc);
    assign wr   = writes_rd(opc) && rda != '0;

    // A writeback landing this cycle already resolves its register's hazard
    assign wb_clr   = wb_valid ? NREG'(1) << wb_addr : '0;
    assign busy     = pending & ~wb_clr;
    assign hazard   = (u1 && busy[rs1a]) || (u2 && busy[rs2a]) || (wr && busy[rda]);
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign issue    = in_valid && in_ready;
    assign pend_set = issue && wr ? NREG'(1) << rda : '0;

    reg_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_valid),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1a),
        .rdata1 (rd1),
        .raddr2 (rs2a),
        .rdata2 (rd2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_rs1   <= '0;
            out_rs2   <= '0;
        end else begin
            pending <= (pending & ~wb_clr) | pend_set;
            if (issue) begin
                out_valid <= 1'b1;
                out_inst  <= in_inst;
                out_rs1   <= rd1;
                out_rs2   <= rd2;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reg_issue.sv
// tb_reg_issue: directed plan plus randomized traffic checked against an array-based issue model
module tb_reg_issue;
    logic        clk = 0, rst = 0;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 0, wb_valid = 0;
    logic [31:0] in_inst = 0, out_inst, out_rs1, out_rs2, wb_data = 0;
    logic [4:0]  wb_addr = 0;
    int          n_chk = 0, n_fail = 0;

    logic [31:0] m_regs [32];
    logic        m_pend [32];
    logic        m_ov;
    logic [31:0] m_inst, m_rs1, m_rs2;

    reg_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_rs1(out_rs1), .out_rs2(out_rs2),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int r1, input int r2);
        return {7'd0, 5'(r2), 5'(r1), 3'd0, 5'(rd), op};
    endfunction

    function automatic logic m_busy(input logic [4:0] a, input logic wv, input logic [4:0] wa);
        return a != 0 && m_pend[a] && !(wv && wa == a);
    endfunction

    function automatic logic m_hazard(input logic [31:0] i, input logic wv, input logic [4:0] wa);
        logic [6:0] op = i[6:0];
        logic u1 = !(op inside {7'h37, 7'h17, 7'h6f});
        logic u2 = op inside {7'h33, 7'h23, 7'h63};
        logic w  = op inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h03} && i[11:7] != 0;
        return (u1 && m_busy(i[19:15], wv, wa)) || (u2 && m_busy(i[24:20], wv, wa)) || (w && m_busy(i[11:7], wv, wa));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic wv, input logic [4:0] wa, input logic [31:0] wd);
        return a == 0 ? 32'd0 : (wv && wa == a) ? wd : m_regs[a];
    endfunction

    task automatic m_reset();
        m_ov = 0; m_inst = 0; m_rs1 = 0; m_rs2 = 0;
        for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
    endtask

    task automatic check_out();
        chk("out_valid", out_valid, m_ov);
        chk("out_inst", out_inst, m_inst);
        chk("out_rs1", out_rs1, m_rs1);
        chk("out_rs2", out_rs2, m_rs2);
    endtask

    // One clock: drive at the falling edge, check in_ready, step the model at the rising edge, check outputs
    task automatic cyc(input logic v, input logic [31:0] inst, input logic ordy,
                       input logic wv, input logic [4:0] wa, input logic [31:0] wd);
        logic exp_rdy, iss, w;
        in_valid = v; in_inst = inst; out_ready = ordy; wb_valid = wv; wb_addr = wa; wb_data = wd;
        #1;
        exp_rdy = (!m_ov || ordy) && !m_hazard(inst, wv, wa);
        chk("in_ready", in_ready, exp_rdy);
        iss = v && exp_rdy;
        w = inst[6:0] inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h03} && inst[11:7] != 0;
        @(posedge clk);
        if (iss) begin
            m_ov = 1; m_inst = inst;
            m_rs1 = m_read(inst[19:15], wv, wa, wd);
            m_rs2 = m_read(inst[24:20], wv, wa, wd);
        end else if (ordy) m_ov = 0;
        if (wv && wa != 0) begin m_regs[wa] = wd; m_pend[wa] = 0; end
        if (iss && w) m_pend[inst[11:7]] = 1;
        #1;
        check_out();
        @(negedge clk);
    endtask

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h23, 7'h63, 7'h73};

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        check_out();
        rst = 1;
        @(negedge clk);
        // Plan 1/2: bypassed writebacks feed add x1,x1,x2; RAW on x1 then forwarded wb
        cyc(0, 0, 1, 1, 1, 32'hCAFEBABE);
        cyc(0, 0, 1, 1, 2, 32'hDEADBEEF);
        cyc(1, 32'h002080B3, 1, 0, 0, 0);
        chk("t1_rs1", out_rs1, 32'hCAFEBABE);
        chk("t1_rs2", out_rs2, 32'hDEADBEEF);
        cyc(1, 32'h002081B3, 1, 0, 0, 0);
        cyc(1, 32'h002081B3, 1, 1, 1, 32'hA9AC79AD);
        chk("t1_fwd", out_rs1, 32'hA9AC79AD);
        cyc(1, mk(7'h33, 1, 1, 2), 1, 0, 0, 0);
        cyc(1, mk(7'h33, 4, 1, 2), 1, 0, 0, 0);
        chk("t2_stall", out_inst, mk(7'h33, 1, 1, 2));
        cyc(1, mk(7'h33, 4, 1, 2), 1, 1, 1, 32'h5);
        chk("t2_fwd", out_rs1, 32'h5);
        // Plan 3: backpressure
        for (int i = 0; i < 3; i++) cyc(1, mk(7'h13, 6, 2, 0), 0, 0, 0, 0);
        chk("t3_hold", out_inst, mk(7'h33, 4, 1, 2));
        cyc(1, mk(7'h13, 6, 2, 0), 1, 0, 0, 0);
        chk("t3_accept", out_inst, mk(7'h13, 6, 2, 0));
        // Plan 4: x0
        cyc(1, 32'h00000033, 1, 1, 0, 32'hFFFFFFFF);
        cyc(1, mk(7'h33, 0, 0, 0), 1, 0, 0, 0);
        chk("t4_x0", out_rs1 | out_rs2, 0);
        // Plan 5: set beats clear, then WAW stall
        cyc(1, 32'h00100293, 1, 0, 0, 0);
        cyc(1, 32'h00100293, 1, 1, 5, 32'h55);
        cyc(1, 32'h00100293, 1, 0, 0, 0);
        chk("t5_waw", in_ready, 0);
        cyc(1, 32'h00100293, 1, 1, 5, 32'h66);
        // Plan 6: async reset between edges with output valid and x5 pending
        #2 rst = 0;
        in_valid = 1; in_inst = mk(7'h33, 7, 5, 5); out_ready = 0; wb_valid = 0;
        #1;
        m_reset();
        chk("t6_ovalid", out_valid, 0);
        chk("t6_ready", in_ready, 1);
        check_out();
        in_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        // Randomized traffic over x0..x7 to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] inst = $urandom();
            logic [4:0]  wa = 5'($urandom_range(0, 7));
            logic        wv = $urandom_range(0, 9) < 5;
            inst[6:0]   = ops[$urandom_range(0, 9)];
            inst[11:7]  = 5'($urandom_range(0, 7));
            inst[19:15] = 5'($urandom_range(0, 7));
            inst[24:20] = 5'($urandom_range(0, 7));
            for (int k = 0; k < 4 && !m_pend[wa]; k++) wa = 5'($urandom_range(0, 7));
            cyc($urandom_range(0, 3) != 0, inst, $urandom_range(0, 3) != 0, wv, wa, $urandom());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_issue.md
Name: reg_issue

Overview:
- Operand-issue stage that feeds the ALU: accepts a decoded-stage instruction and reads rs1/rs2 from a 32-entry integer register file.
- Presents inst/rs1/rs2 to the ALU through a registered valid/ready output.
- Accepts the ALU's rd result on a writeback port, the other end of the ALU's inst/rs1/rs2 -> rd interface.
- Holds a per-register pending scoreboard, stalls RAW/WAW hazards, and forwards same-cycle writeback data into operand capture.

Parameters:
XLEN, 32, data width of registers, operands and writeback
NREG, 32, number of architectural registers (x0 hard-wired zero)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  issue accepts in_inst this cycle
in_inst  in  32  RV32I instruction word
out_valid  out  1  out_* hold an issued instruction
out_ready  in  1  ALU consumes out_* this cycle
out_inst  out  32  issued instruction
out_rs1  out  XLEN  rs1 operand value
out_rs2  out  XLEN  rs2 operand value
wb_valid  in  1  writeback strobe from ALU stage
wb_addr  in  5  destination register
wb_data  in  XLEN  result value

Behaviour:
- Reset (rst low, async): regs x1..x31 = 0, pending[*] = 0, out_valid = 0, out_inst = 0, out_rs1 = 0, out_rs2 = 0.
- Field extraction: rs1a = inst[19:15], rs2a = inst[24:20], rda = inst[11:7], opcode = inst[6:0].
- Usage decode:
  - uses_rs1 unless opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
  - uses_rs2 for OP 0110011, STORE 0100011, BRANCH 1100011.
  - writes_rd for OP, OP-IMM 0010011, LUI, AUIPC, JAL, JALR 1100111, LOAD 0000011, and only when rda != 0.
- Effective pending: busy(a) = pending[a] && !(wb_valid && wb_addr == a). Address 0 is never busy.
- Hazard = (uses_rs1 && busy(rs1a)) || (uses_rs2 && busy(rs2a)) || (writes_rd && busy(rda)).
- in_ready = (!out_valid || out_ready) && !hazard. in_ready is combinational and may depend on in_inst.
- Issue latency is 1 cycle. On in_valid && in_ready at edge N, at N+1:
  - out_valid = 1, out_inst = in_inst.
  - out_rs1/out_rs2 = read value, forwarded from wb_data when wb_valid && wb_addr matches a nonzero source.
  - Address 0 always reads 0.
- Output hold: out_valid && !out_ready keeps every out_* stable. Consumption without a new issue clears out_valid; out_inst and operands hold their stale values.
- Writeback: wb_valid && wb_addr != 0 writes regs[wb_addr] and clears pending[wb_addr]. wb_addr == 0 is ignored. Writeback to a non-pending register is legal: it writes and pending stays 0.
- Issue with writes_rd sets pending[rda]. If issue sets pending[X] in the same cycle writeback clears X, the set wins.
- Scoreboard allows at most one outstanding writer per register; WAW stalls.
- Reset mid-operation discards the held output and all pending bits immediately, without waiting for a clock edge.

Decomposition:
- Shared package `rv_defs`: opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH), field bit ranges, XLEN.
- Sub-module `reg_file`: NREG x XLEN, 2 async read ports, 1 write port, x0 = 0, write-through bypass. reg_issue holds the scoreboard, handshake and output register.

Test Plan:
1. Reset bypass:
   - Stimulus: after reset, wb x1 = CAFEBABE, x2 = DEADBEEF, then issue 0x002080B3 (add x1,x1,x2).
   - Response: out_rs1 = CAFEBABE, out_rs2 = DEADBEEF, out_valid 1 cycle after accept, pending[1] = 1.
   - Then drive wb x1 = A9AC79AD; pending[1] clears.
2. RAW stall then forward:
   - Stimulus: issue add x3,x1,x2 with x1 pending; in_ready = 0. Next cycle wb x1 = 00000005 with in_valid held.
   - Response: in_ready = 1 that cycle; out_rs1 = 00000005.
3. Backpressure:
   - Stimulus: out_ready = 0 for 3 cycles with in_valid = 1.
   - Response: out_* stable and in_ready = 0 throughout; out_ready = 1 accepts the next instruction the following cycle.
4. x0 handling:
   - Stimulus: issue add x0,x0,x0 and wb x0 = FFFFFFFF.
   - Response: operands 0; no stall; pending unchanged; later read of x0 = 0.
5. Simultaneous set/clear and WAW:
   - Stimulus: issue addi x5 while wb x5 arrives.
   - Response: pending[5] = 1 after the edge; an immediate second addi x5 stalls until the next wb x5.
6. Async reset mid-stream:
   - Stimulus: assert rst low between edges with out_valid = 1.
   - Response: out_valid = 0 and pending = 0 without a clock edge.
